// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline boundary register with stall/flush handling for the in-order core.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_reg #(
    parameter int                DATA_W      = 32,
    parameter int                STALL_W     = 6,
    parameter int                STAGE       = 2,
    parameter int                BUBBLE_ZERO = 1,
    parameter logic [DATA_W-1:0] RESET_VAL   = {DATA_W{1'b0}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               i_valid,
    input  logic [DATA_W-1:0]  i_data,
    output logic               o_valid,
    output logic [DATA_W-1:0]  o_data,
    output logic [15:0]        o_stall_cnt,
    output logic [15:0]        o_bubble_cnt,
    input  logic               cnt_clr
);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic s_up;
    logic s_dn;
    logic squash;
    logic vld_p0;
    logic [DATA_W-1:0] data_p0;

    assign s_up = stall[STAGE];

    // The last stage has no downstream stall bit; it behaves as if downstream always proceeds.
    generate
        if (STAGE < STALL_W-1) begin : g_dn
            assign s_dn = stall[STAGE+1];
        end else begin : g_top
            assign s_dn = 1'b0;
        end
    endgenerate

    assign squash = flush | (s_up & ~s_dn);

    // Boundary register: reset > flush > bubble > load > hold
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            data_p0 <= RESET_VAL;
        end else if (squash) begin
            vld_p0 <= 1'b0;
            if (BUBBLE_ZERO != 0) begin
                data_p0 <= RESET_VAL;
            end
        end else if (!s_up) begin
            vld_p0  <= i_valid;
            data_p0 <= i_data;
        end
    end

    assign o_valid = vld_p0;
    assign o_data  = data_p0;

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic        ev_bubble;
    logic        ev_hold;
    logic [15:0] stall_cnt_p0;
    logic [15:0] bubble_cnt_p0;
    logic        unused_stall;

    assign ev_bubble = ~flush & s_up & ~s_dn;
    assign ev_hold   = ~flush & s_up & s_dn & vld_p0;

    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            stall_cnt_p0  <= 16'h0000;
            bubble_cnt_p0 <= 16'h0000;
        end else begin
            if (ev_hold) begin
                stall_cnt_p0 <= sat_inc(stall_cnt_p0);
            end
            if (ev_bubble) begin
                bubble_cnt_p0 <= sat_inc(bubble_cnt_p0);
            end
        end
    end

    assign o_stall_cnt  = stall_cnt_p0;
    assign o_bubble_cnt = bubble_cnt_p0;
    assign unused_stall = ^stall;
`else
    logic unused_in;

    assign o_stall_cnt  = 16'h0000;
    assign o_bubble_cnt = 16'h0000;
    assign unused_in    = ^{stall, cnt_clr, sat_inc(16'h0000)};
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: three instances (mid stage zeroing, mid stage holding payload,
// top stage) share one stimulus stream; a monitor pops hand-computed expectations each cycle.
module tb_pipe_stage_reg;

    typedef struct {
        logic        av;
        logic [31:0] ad;
        logic        bv;
        logic [31:0] bd;
        logic        cv;
        logic [31:0] cd;
        logic [15:0] bub;
        logic [15:0] stl;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic        i_valid = 1'b1;
    logic [31:0] i_data = 32'hDEADBEEF;
    logic        cnt_clr = 1'b0;

    logic        a_valid, b_valid, c_valid;
    logic [31:0] a_data, b_data, c_data;
    logic [15:0] a_stl, a_bub, b_stl, b_bub, c_stl, c_bub;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .STALL_W(6), .STAGE(2), .BUBBLE_ZERO(1)) dut_a (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .i_valid(i_valid), .i_data(i_data),
        .o_valid(a_valid), .o_data(a_data), .o_stall_cnt(a_stl), .o_bubble_cnt(a_bub), .cnt_clr(cnt_clr));

    pipe_stage_reg #(.DATA_W(32), .STALL_W(6), .STAGE(2), .BUBBLE_ZERO(0)) dut_b (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .i_valid(i_valid), .i_data(i_data),
        .o_valid(b_valid), .o_data(b_data), .o_stall_cnt(b_stl), .o_bubble_cnt(b_bub), .cnt_clr(cnt_clr));

    pipe_stage_reg #(.DATA_W(32), .STALL_W(6), .STAGE(5), .BUBBLE_ZERO(1)) dut_c (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .i_valid(i_valid), .i_data(i_data),
        .o_valid(c_valid), .o_data(c_data), .o_stall_cnt(c_stl), .o_bubble_cnt(c_bub), .cnt_clr(cnt_clr));

    function automatic logic [15:0] cnt_exp(input logic [15:0] v);
`ifdef PIPE_STAGE_PERF_CNT_EN
        return v;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic [5:0] stl_v, input logic fl, input logic iv,
                        input logic [31:0] d, input logic clr,
                        input logic av, input logic [31:0] ad, input logic bv, input logic [31:0] bd,
                        input logic cv, input logic [31:0] cd, input logic [15:0] bub, input logic [15:0] stl);
        exp_t e;
        @(negedge clk);
        reset   = rst;
        stall   = stl_v;
        flush   = fl;
        i_valid = iv;
        i_data  = d;
        cnt_clr = clr;
        e.av = av; e.ad = ad; e.bv = bv; e.bd = bd;
        e.cv = cv; e.cd = cd; e.bub = bub; e.stl = stl;
        sb.push_back(e);
    endtask

    // Monitor: one registered result per edge, sampled just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("a_valid", {31'b0, a_valid}, {31'b0, e.av});
                chk("a_data", a_data, e.ad);
                chk("b_valid", {31'b0, b_valid}, {31'b0, e.bv});
                chk("b_data", b_data, e.bd);
                chk("c_valid", {31'b0, c_valid}, {31'b0, e.cv});
                chk("c_data", c_data, e.cd);
                chk("a_bubble_cnt", {16'b0, a_bub}, {16'b0, cnt_exp(e.bub)});
                chk("a_stall_cnt", {16'b0, a_stl}, {16'b0, cnt_exp(e.stl)});
            end
        end
    end

    initial begin
        int guard;
        // rst stall fl iv data clr | a_v a_d | b_v b_d | c_v c_d | bub stl
        step(1, 6'b000000, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0);
        step(1, 6'b000000, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0);
        step(0, 6'b000000, 0, 1, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0);
        step(0, 6'b000100, 0, 1, 32'h12345678, 0, 0, 32'h0, 0, 32'hDEADBEEF, 1, 32'h12345678, 1, 0);
        step(0, 6'b000000, 0, 1, 32'hA5A5A5A5, 0, 1, 32'hA5A5A5A5, 1, 32'hA5A5A5A5, 1, 32'hA5A5A5A5, 1, 0);
        step(0, 6'b001100, 0, 1, 32'h11111111, 0, 1, 32'hA5A5A5A5, 1, 32'hA5A5A5A5, 1, 32'h11111111, 1, 1);
        step(0, 6'b001100, 0, 1, 32'h22222222, 0, 1, 32'hA5A5A5A5, 1, 32'hA5A5A5A5, 1, 32'h22222222, 1, 2);
        step(0, 6'b001100, 0, 1, 32'h33333333, 0, 1, 32'hA5A5A5A5, 1, 32'hA5A5A5A5, 1, 32'h33333333, 1, 3);
        step(0, 6'b001100, 1, 1, 32'h44444444, 0, 0, 32'h0, 0, 32'hA5A5A5A5, 0, 32'h0, 1, 3);
        step(0, 6'b000000, 1, 1, 32'h00000001, 0, 0, 32'h0, 0, 32'hA5A5A5A5, 0, 32'h0, 1, 3);
        step(0, 6'b100000, 0, 1, 32'hCAFEF00D, 0, 1, 32'hCAFEF00D, 1, 32'hCAFEF00D, 0, 32'h0, 1, 3);
        step(0, 6'b001100, 0, 1, 32'h0BADF00D, 0, 1, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1, 32'h0BADF00D, 1, 4);
        step(0, 6'b001100, 0, 1, 32'h0BADF00D, 1, 1, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1, 32'h0BADF00D, 0, 0);
        step(0, 6'b000000, 0, 0, 32'h77777777, 0, 0, 32'h77777777, 0, 32'h77777777, 0, 32'h77777777, 0, 0);
        step(0, 6'b001100, 0, 0, 32'h88888888, 0, 0, 32'h77777777, 0, 32'h77777777, 0, 32'h88888888, 0, 0);
        step(0, 6'b001000, 0, 1, 32'h99999999, 0, 1, 32'h99999999, 1, 32'h99999999, 1, 32'h99999999, 0, 0);
        step(1, 6'b001100, 1, 1, 32'h12121212, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0);
        step(0, 6'b000000, 0, 0, 32'h00000000, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0);
        step(0, 6'b000100, 0, 1, 32'h00000005, 0, 0, 32'h0, 0, 32'h0, 1, 32'h00000005, 1, 0);
`ifdef PIPE_STAGE_PERF_CNT_EN
        step(0, 6'b000000, 0, 1, 32'h0000AAAA, 0, 1, 32'h0000AAAA, 1, 32'h0000AAAA, 1, 32'h0000AAAA, 1, 0);
        @(posedge clk);
        #2;
        force dut_a.stall_cnt_p0 = 16'hFFFE;
        release dut_a.stall_cnt_p0;
        step(0, 6'b001100, 0, 1, 32'h000000B1, 0, 1, 32'h0000AAAA, 1, 32'h0000AAAA, 1, 32'h000000B1, 1, 16'hFFFF);
        step(0, 6'b001100, 0, 1, 32'h000000B2, 0, 1, 32'h0000AAAA, 1, 32'h0000AAAA, 1, 32'h000000B2, 1, 16'hFFFF);
        step(0, 6'b001100, 0, 1, 32'h000000B3, 0, 1, 32'h0000AAAA, 1, 32'h0000AAAA, 1, 32'h000000B3, 1, 16'hFFFF);
        step(0, 6'b001100, 0, 1, 32'h000000B4, 1, 1, 32'h0000AAAA, 1, 32'h0000AAAA, 1, 32'h000000B4, 0, 0);
`endif
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline boundary register for the in-order MIPS core.
- Replaces the hand-written per-stage registers (if/id, id/exe, exe/mem, mem/wb) with one block.
- Carries an arbitrary payload plus a valid bit. Obeys the global stall vector from the stall controller and adds a synchronous flush for branch/exception squash.
- Placed once per stage boundary; STAGE selects which stall bits it obeys.

Parameters:
- DATA_W, 32, payload width in bits (1..1024); the concatenation of all control/data fields crossing the boundary.
- STALL_W, 6, width of the global stall vector.
- STAGE, 2, index of the upstream stage in the stall vector; valid range 0..STALL_W-1.
- BUBBLE_ZERO, 1:
  - 1: payload is forced to RESET_VAL on bubble/flush.
  - 0: only o_valid is cleared and the payload holds its old value (saves enable fan-out).
- RESET_VAL, {DATA_W{1'b0}}, payload value on reset, and on bubble/flush when BUBBLE_ZERO=1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  STALL_W  global stall vector; 1 = stop.
- flush  in  1  synchronous squash of this boundary.
- i_valid  in  1  upstream entry is a real instruction.
- i_data  in  DATA_W  upstream payload.
- o_valid  out  1  registered valid.
- o_data  out  DATA_W  registered payload.
- o_stall_cnt  out  16  saturating count of hold cycles with o_valid=1 (optional feature).
- o_bubble_cnt  out  16  saturating count of bubbles inserted (optional feature).
- cnt_clr  in  1  synchronous clear of both counters (optional feature).

Behaviour:
- Clock is clk; reset is synchronous, active-high.
- Signals used below:
  - s_up = stall[STAGE].
  - s_dn = stall[STAGE+1] when STAGE < STALL_W-1, else constant 0.
- Registered; latency exactly 1 cycle from a load to o_valid/o_data.
- Per-edge priority, highest first:
  1. reset: o_valid=0, o_data=RESET_VAL, counters=0.
  2. flush: o_valid=0; o_data=RESET_VAL if BUBBLE_ZERO else unchanged. Overrides any stall combination, including s_up=1,s_dn=1.
  3. bubble (s_up=1, s_dn=0): o_valid=0; o_data as for flush. Upstream is frozen while downstream proceeds, so nothing may be duplicated downstream.
  4. load (s_up=0): o_valid=i_valid, o_data=i_data. s_dn is ignored; the stall controller guarantees s_dn=1 implies s_up=1.
  5. hold (s_up=1, s_dn=1): o_valid and o_data unchanged.
- A load with i_valid=0 stores the payload as given (no zeroing) and sets o_valid=0.
- Flush and load in the same cycle: flush wins; the incoming entry is dropped.
- Reset asserted mid-stall or mid-flush: reset wins on that edge; the first cycle after reset deasserts behaves as an idle register (o_valid=0).
- Illegal stall pattern s_up=0, s_dn=1: treated as load. The block does not check for it.
- No combinational path from any input to any output.

Optional Feature:
- Macro: PIPE_STAGE_PERF_CNT_EN.
- Defined:
  - o_stall_cnt increments on each hold edge where o_valid=1.
  - o_bubble_cnt increments on each bubble edge; flush edges are not counted.
  - Both counters saturate at 16'hFFFF (no wrap).
  - cnt_clr zeroes both on the next edge and has priority over an increment in the same cycle. reset also clears them.
- Not defined:
  - Counter registers are not instantiated; o_stall_cnt and o_bubble_cnt are tied to 16'h0000 and cnt_clr is ignored.
  - Ports remain present so instantiation is identical in both builds.

Test Plan:
- Reset: hold reset 2 cycles with i_valid=1, i_data=32'hDEADBEEF, stall=0 -> o_valid=0, o_data=0, counters=0; first edge after release -> o_valid=1, o_data=32'hDEADBEEF.
- Bubble: STAGE=2, stall=6'b000100, i_data=32'h12345678 -> next edge o_valid=0, o_data=0 (BUBBLE_ZERO=1), o_bubble_cnt=1. With BUBBLE_ZERO=0 the prior o_data is retained.
- Hold: load 32'hA5A5A5A5, then stall=6'b001100 for 3 cycles while i_data changes -> o_data stays 32'hA5A5A5A5, o_valid=1, o_stall_cnt=3.
- Flush priority: stall=6'b001100 with flush=1 -> o_valid=0 on next edge. Flush with stall=0 and i_data=32'h1 -> entry dropped, o_valid=0.
- Top stage: STAGE=5, stall=6'b100000 -> bubble (s_dn treated as 0), o_valid=0.
- Counter saturation (macro defined): preload o_stall_cnt to 16'hFFFE via force, apply 3 hold cycles -> reads 16'hFFFF. cnt_clr=1 together with a hold -> 16'h0000.
